// File: rtl/keysearch_coordinator.sv
// keysearch_coordinator
// Launches a bank of parallel RC4 key-search cores, watches their status
// pulses, latches the first winning key/core, aborts the losers and holds
// a search result (found/fail, key, core, elapsed cycles) for readout.
module keysearch_coordinator #(
    parameter int NUM_CORES      = 4,
    parameter int CORE_IDX_WIDTH = 2,
    parameter int KEY_LENGTH     = 3,
    parameter int RAM_WIDTH      = 8,
    parameter int ABORT_CYCLES   = 2,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        go,
    output logic [NUM_CORES-1:0]                        core_start,
    output logic                                        core_abort,
    input  logic [NUM_CORES-1:0]                        core_succeeded,
    input  logic [NUM_CORES-1:0]                        core_terminated,
    input  logic [NUM_CORES*KEY_LENGTH*RAM_WIDTH-1:0]   core_key,
    output logic [KEY_LENGTH*RAM_WIDTH-1:0]             found_key,
    output logic [CORE_IDX_WIDTH-1:0]                   found_core,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        found,
    output logic [CNT_WIDTH-1:0]                        elapsed
);

    localparam int KEY_WIDTH = KEY_LENGTH * RAM_WIDTH;
    // Abort counter counts down from ABORT_CYCLES-1 to 0; at least one bit.
    localparam int ACW = (ABORT_CYCLES > 1) ? $clog2(ABORT_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        SEARCH,
        ABORT,
        DONE_FOUND,
        DONE_FAIL
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   go_q;
    logic                   go_rise;
    logic                   launch;
    logic [NUM_CORES-1:0]   term_seen;
    logic [ACW-1:0]         abort_cnt;
    logic                   win_valid;
    logic [CORE_IDX_WIDTH-1:0] win_idx;
    logic [KEY_WIDTH-1:0]   win_key;
    logic                   all_term;

    // Priority pick of the lowest-index core reporting success this cycle.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        win_key   = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (core_succeeded[i]) begin
                win_valid = 1'b1;
                win_idx   = CORE_IDX_WIDTH'(i);
                win_key   = core_key[i*KEY_WIDTH +: KEY_WIDTH];
            end
        end
    end

    // Next-state decode; a new search may only start when not busy.
    always_comb begin
        state_next = state;
        go_rise    = go & ~go_q;
        launch     = 1'b0;
        all_term   = &(term_seen | core_terminated);
        case (state)
            IDLE, DONE_FOUND, DONE_FAIL: begin
                if (go_rise) begin
                    launch     = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                state_next = SEARCH;
            end
            SEARCH: begin
                if (win_valid) begin
                    state_next = ABORT;
                end else if (all_term) begin
                    state_next = DONE_FAIL;
                end
            end
            ABORT: begin
                if (abort_cnt == '0) begin
                    state_next = DONE_FOUND;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register plus the registered copy of go for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            go_q  <= 1'b0;
        end else begin
            state <= state_next;
            go_q  <= go;
        end
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_start <= '0;
            core_abort <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
        end else begin
            core_start <= (state_next == LAUNCH) ? '1 : '0;
            core_abort <= (state_next == ABORT);
            busy       <= (state_next == LAUNCH) || (state_next == SEARCH) ||
                          (state_next == ABORT);
            done       <= (state_next == DONE_FOUND) || (state_next == DONE_FAIL);
            found      <= (state_next == DONE_FOUND);
        end
    end

    // Search bookkeeping: elapsed time, sticky terminations and the winner latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            elapsed    <= '0;
            term_seen  <= '0;
            found_key  <= '0;
            found_core <= '0;
        end else if (launch) begin
            elapsed    <= '0;
            term_seen  <= '0;
            found_key  <= '0;
            found_core <= '0;
        end else if (state == SEARCH) begin
            if (elapsed != '1) begin
                elapsed <= elapsed + CNT_WIDTH'(1);
            end
            term_seen <= term_seen | core_terminated;
            if (win_valid) begin
                found_key  <= win_key;
                found_core <= win_idx;
            end
        end
    end

    // Abort hold timer, loaded on the winning cycle and run down during ABORT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            abort_cnt <= '0;
        end else if ((state == SEARCH) && win_valid) begin
            abort_cnt <= ACW'(ABORT_CYCLES - 1);
        end else if ((state == ABORT) && (abort_cnt != '0)) begin
            abort_cnt <= abort_cnt - ACW'(1);
        end
    end

endmodule

// File: doc/keysearch_coordinator.md
Name: keysearch_coordinator

Overview:
- Downstream consumer of NUM_CORES parallel RC4 cracking cores, each searching its own fixed key sub-range.
- Launches all cores together, watches their one-cycle succeeded/terminated status, and latches the first winning key and core index.
- Aborts the losing cores after a win.
- Presents a held search result (found/fail, key, core, elapsed cycles) to the board-level display/readout logic.

Parameters:
- NUM_CORES, 4, number of cracking cores driven and monitored.
- CORE_IDX_WIDTH, 2, width of the core index; must satisfy 2**CORE_IDX_WIDTH >= NUM_CORES.
- KEY_LENGTH, 3, bytes per key.
- RAM_WIDTH, 8, bits per key byte.
- ABORT_CYCLES, 2, cycles that core_abort is held high after a win (minimum 1).
- CNT_WIDTH, 32, width of the elapsed-cycle counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- go  input  1  level request; a search launches on its rising edge, detected internally with a registered copy.
- core_start  output  NUM_CORES  start request to each core.
- core_abort  output  1  registered synchronous reset driven to all cores.
- core_succeeded  input  NUM_CORES  per-core one-cycle success pulse.
- core_terminated  input  NUM_CORES  per-core one-cycle termination pulse; high on both success and fail.
- core_key  input  NUM_CORES*KEY_LENGTH*RAM_WIDTH  per-core current key; core n occupies slice n.
- found_key  output  KEY_LENGTH*RAM_WIDTH  latched winning key.
- found_core  output  CORE_IDX_WIDTH  index of the winning core.
- busy  output  1  high in LAUNCH, SEARCH and ABORT.
- done  output  1  high in DONE_FOUND or DONE_FAIL.
- found  output  1  high in DONE_FOUND only.
- elapsed  output  CNT_WIDTH  number of cycles spent in SEARCH.

Behaviour:
- Reset (async): state=IDLE and go_q=0; every output is 0, including core_start, core_abort, found_key, found_core, elapsed and term_seen.
- Reset mid-search forces IDLE immediately. Cores are not aborted by this block in that case; they share the same reset.
- go_rise = go & ~go_q. go_rise is ignored unless the state is IDLE, DONE_FOUND or DONE_FAIL.
- IDLE / DONE_*:
  - On go_rise: clear term_seen, elapsed, found_key and found_core, then go to LAUNCH.
  - DONE_* outputs hold until go_rise.
- LAUNCH (exactly 1 cycle): core_start = all ones, registered. Next state is SEARCH.
- SEARCH:
  - core_start = 0.
  - elapsed increments by 1 each cycle and saturates at all ones.
  - term_seen |= core_terminated each cycle (sticky).
  - If any core_succeeded bit is set: latch found_core = lowest set index and found_key = core_key slice of that index in the same cycle, then go to ABORT.
  - Else if (term_seen | core_terminated) is all ones: go to DONE_FAIL.
  - Success has priority over fail-completion in the same cycle.
  - Among simultaneous successes, the lowest index wins.
- ABORT:
  - core_abort = 1 for exactly ABORT_CYCLES cycles, timed by a down-counter, then DONE_FOUND.
  - core_succeeded pulses arriving during ABORT are ignored; the found_* registers are never overwritten.
- DONE_FOUND: found = 1, done = 1. DONE_FAIL: found = 0, done = 1; found_key and found_core stay 0.
- The elapsed counter freezes on leaving SEARCH.
- All outputs are registered (no combinational input-to-output path).
- Latency:
  - go_rise to core_start high: 1 cycle.
  - success pulse to core_abort high: 1 cycle.
  - success pulse to done: ABORT_CYCLES + 1 cycles.

Test Plan:
- Basic win: go 0->1. Expect core_start=4'b1111 for one cycle. Then core 2 pulses succeeded with key 0x00_3A_7F at SEARCH cycle 10 -> found_core=2, found_key=0x003A7F, core_abort high for 2 cycles, then done=1, found=1, elapsed=10.
- Simultaneous success: cores 1 and 3 pulse succeeded in the same cycle with different keys -> found_core=1 with core 1's key; a later core 3 pulse during ABORT changes nothing.
- All fail: cores terminate (no success) at cycles 5, 9, 9, 20 -> DONE_FAIL at cycle 20 with found=0, found_key=0, elapsed=20, core_abort never asserted.
- Success in the final-termination cycle: cores 0–2 already terminated; core 3 pulses succeeded and terminated together -> DONE_FOUND with found_core=3.
- go held high or re-toggled while busy -> no relaunch. After done, a new go_rise clears found/elapsed and re-pulses core_start.
- Async reset asserted mid-SEARCH (between clock edges) -> all outputs 0 immediately. After release, the block waits in IDLE for go_rise.
